// File: rtl/hazard_stall_controller.sv
// Pipeline hazard/stall sequencer: RAW stalls, taken-branch flush, SRAM wait-state freeze with timeout.
// Optional HAZARD_FORWARDING_EN: with forwarding present only load-use hazards stall.
module hazard_stall_controller #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_src1,
    input  logic [4:0]       id_src2,
    input  logic             id_two_src,
    input  logic             id_br_taken,
    input  logic [4:0]       exe_dest,
    input  logic             exe_wb_en,
    input  logic             exe_mem_r_en,
    input  logic [4:0]       mem_dest,
    input  logic             mem_wb_en,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             freeze_pc,
    output logic             freeze_if_id,
    output logic             bubble_id_exe,
    output logic             flush_if_id,
    output logic             freeze_back,
    output logic             fwd_en,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cnt,
    output logic             state_dbg
);

    typedef enum logic {
        ST_RUN      = 1'b0,
        ST_MEM_WAIT = 1'b1
    } state_t;

    localparam logic [15:0]      TIMEOUT_VAL = 16'(MEM_TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_MAX     = '1;

    state_t           state_q;
    logic [15:0]      wait_cnt_q;
    logic             mem_timeout_q;
    logic [CNT_W-1:0] stall_cnt_q;

    logic raw_hz;
    logic mem_wait;
    logic at_timeout;

`ifdef HAZARD_FORWARDING_EN
    // Forwarding covers ALU results; only a load in EXE cannot be bypassed in time.
    logic unused_mem_stage;
    assign unused_mem_stage = mem_wb_en ^ (^mem_dest);
    assign fwd_en = 1'b1;
    assign raw_hz = exe_wb_en && exe_mem_r_en && (exe_dest != 5'd0) &&
                    ((id_src1 == exe_dest) || (id_two_src && (id_src2 == exe_dest)));
`else
    logic unused_load_flag;
    logic exe_hit;
    logic mem_hit;
    assign unused_load_flag = exe_mem_r_en;
    assign fwd_en  = 1'b0;
    assign exe_hit = exe_wb_en && (exe_dest != 5'd0) &&
                     ((id_src1 == exe_dest) || (id_two_src && (id_src2 == exe_dest)));
    assign mem_hit = mem_wb_en && (mem_dest != 5'd0) &&
                     ((id_src1 == mem_dest) || (id_two_src && (id_src2 == mem_dest)));
    assign raw_hz  = exe_hit || mem_hit;
`endif

    // The timeout cycle itself is not a wait: the MEM instruction is released.
    assign at_timeout = (state_q == ST_MEM_WAIT) && !mem_ready && (wait_cnt_q == TIMEOUT_VAL);
    assign mem_wait   = ((state_q == ST_RUN) && mem_req && !mem_ready) ||
                        ((state_q == ST_MEM_WAIT) && !mem_ready && !at_timeout);

    always_comb begin
        freeze_pc     = 1'b0;
        freeze_if_id  = 1'b0;
        bubble_id_exe = 1'b0;
        flush_if_id   = 1'b0;
        freeze_back   = 1'b0;
        if (rst) begin
            if (mem_wait) begin
                freeze_pc    = 1'b1;
                freeze_if_id = 1'b1;
                freeze_back  = 1'b1;
            end else if (raw_hz) begin
                freeze_pc     = 1'b1;
                freeze_if_id  = 1'b1;
                bubble_id_exe = 1'b1;
            end else if (id_br_taken) begin
                flush_if_id = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= ST_RUN;
            wait_cnt_q    <= 16'd0;
            mem_timeout_q <= 1'b0;
            stall_cnt_q   <= '0;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (mem_req && !mem_ready) begin
                        state_q    <= ST_MEM_WAIT;
                        wait_cnt_q <= 16'd1;
                    end
                end
                ST_MEM_WAIT: begin
                    if (mem_ready) begin
                        state_q    <= ST_RUN;
                        wait_cnt_q <= 16'd0;
                    end else if (at_timeout) begin
                        state_q       <= ST_RUN;
                        wait_cnt_q    <= 16'd0;
                        mem_timeout_q <= 1'b1;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + 16'd1;
                    end
                end
                default: begin
                    state_q    <= ST_RUN;
                    wait_cnt_q <= 16'd0;
                end
            endcase
            if (freeze_pc && (stall_cnt_q != CNT_MAX)) begin
                stall_cnt_q <= stall_cnt_q + 1'b1;
            end
        end
    end

    assign mem_timeout = mem_timeout_q;
    assign stall_cnt   = stall_cnt_q;
    assign state_dbg   = state_q;

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Directed vector bench for hazard_stall_controller; expectations follow the build's HAZARD_FORWARDING_EN setting.
module tb_hazard_stall_controller;

    logic        clk;
    logic        rst;
    logic [4:0]  id_src1, id_src2, exe_dest, mem_dest;
    logic        id_two_src, id_br_taken, exe_wb_en, exe_mem_r_en, mem_wb_en, mem_req, mem_ready;
    logic        freeze_pc, freeze_if_id, bubble_id_exe, flush_if_id, freeze_back, fwd_en, mem_timeout;
    logic [15:0] stall_cnt;
    logic        state_dbg;

    logic        unused_s_fpc, unused_s_fif, unused_s_bub, unused_s_fl, unused_s_fb, unused_s_fwd;
    logic        unused_s_to, unused_s_st;
    logic [1:0]  s_stall_cnt;

    hazard_stall_controller #(.MEM_TIMEOUT(4), .CNT_W(16)) dut (
        .clk(clk), .rst(rst),
        .id_src1(id_src1), .id_src2(id_src2), .id_two_src(id_two_src), .id_br_taken(id_br_taken),
        .exe_dest(exe_dest), .exe_wb_en(exe_wb_en), .exe_mem_r_en(exe_mem_r_en),
        .mem_dest(mem_dest), .mem_wb_en(mem_wb_en), .mem_req(mem_req), .mem_ready(mem_ready),
        .freeze_pc(freeze_pc), .freeze_if_id(freeze_if_id), .bubble_id_exe(bubble_id_exe),
        .flush_if_id(flush_if_id), .freeze_back(freeze_back), .fwd_en(fwd_en),
        .mem_timeout(mem_timeout), .stall_cnt(stall_cnt), .state_dbg(state_dbg)
    );

    // Narrow-counter instance to observe saturation.
    hazard_stall_controller #(.MEM_TIMEOUT(4), .CNT_W(2)) dut_s (
        .clk(clk), .rst(rst),
        .id_src1(id_src1), .id_src2(id_src2), .id_two_src(id_two_src), .id_br_taken(id_br_taken),
        .exe_dest(exe_dest), .exe_wb_en(exe_wb_en), .exe_mem_r_en(exe_mem_r_en),
        .mem_dest(mem_dest), .mem_wb_en(mem_wb_en), .mem_req(mem_req), .mem_ready(mem_ready),
        .freeze_pc(unused_s_fpc), .freeze_if_id(unused_s_fif), .bubble_id_exe(unused_s_bub),
        .flush_if_id(unused_s_fl), .freeze_back(unused_s_fb), .fwd_en(unused_s_fwd),
        .mem_timeout(unused_s_to), .stall_cnt(s_stall_cnt), .state_dbg(unused_s_st)
    );

    typedef struct {
        logic [4:0] src1;
        logic [4:0] src2;
        logic       two_src;
        logic       br;
        logic [4:0] exe_dest;
        logic       exe_wb;
        logic       exe_ld;
        logic [4:0] mem_dest;
        logic       mem_wb;
        logic       req;
        logic       rdy;
        logic [4:0] exp_nf;  // {freeze_pc, freeze_if_id, bubble, flush, freeze_back} without forwarding
        logic [4:0] exp_fw;  // same, with forwarding
    } vec_t;

    int unsigned n_cmp;
    int unsigned n_err;
    int unsigned exp_stall;
    logic        exp_to;
    vec_t        tbl[14];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic vec_t mk(input logic [4:0] src1, input logic [4:0] src2, input logic two_src,
                                input logic br, input logic [4:0] exe_dest, input logic exe_wb,
                                input logic exe_ld, input logic [4:0] mem_dest, input logic mem_wb,
                                input logic req, input logic rdy, input logic [4:0] exp_nf,
                                input logic [4:0] exp_fw);
        vec_t v;
        v.src1 = src1; v.src2 = src2; v.two_src = two_src; v.br = br;
        v.exe_dest = exe_dest; v.exe_wb = exe_wb; v.exe_ld = exe_ld;
        v.mem_dest = mem_dest; v.mem_wb = mem_wb; v.req = req; v.rdy = rdy;
        v.exp_nf = exp_nf; v.exp_fw = exp_fw;
        return v;
    endfunction

    function automatic logic [4:0] pick(input vec_t v);
`ifdef HAZARD_FORWARDING_EN
        return v.exp_fw;
`else
        return v.exp_nf;
`endif
    endfunction

    task automatic chk(input string name, input int unsigned act, input int unsigned exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        id_src1 = v.src1; id_src2 = v.src2; id_two_src = v.two_src; id_br_taken = v.br;
        exe_dest = v.exe_dest; exe_wb_en = v.exe_wb; exe_mem_r_en = v.exe_ld;
        mem_dest = v.mem_dest; mem_wb_en = v.mem_wb; mem_req = v.req; mem_ready = v.rdy;
    endtask

    // One clock: apply inputs, check outputs and registered state mid-cycle, then advance.
    task automatic step(input string tag, input vec_t v, input logic exp_state);
        logic [4:0] e;
        int unsigned sat;
        e = pick(v);
        drive(v);
        @(negedge clk);
        chk({tag, ".outs"}, {27'd0, freeze_pc, freeze_if_id, bubble_id_exe, flush_if_id, freeze_back},
            {27'd0, e});
        chk({tag, ".state"}, {31'd0, state_dbg}, {31'd0, exp_state});
        chk({tag, ".stall_cnt"}, {16'd0, stall_cnt}, exp_stall);
        sat = (exp_stall > 3) ? 3 : exp_stall;
        chk({tag, ".stall_sat"}, {30'd0, s_stall_cnt}, sat);
        chk({tag, ".timeout"}, {31'd0, mem_timeout}, {31'd0, exp_to});
        if (e[4]) exp_stall++;
        @(posedge clk);
        #1;
    endtask

    vec_t idle;

    initial begin
        int unsigned base;
        n_cmp = 0; n_err = 0; exp_stall = 0; exp_to = 1'b0;
        idle = mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 5'b00000, 5'b00000);

        //            src1 src2 two br  exe_d wb ld  mem_d wb req rdy  exp_nf    exp_fw
        tbl[0]  = mk(5'd1, 5'd2, 1'b1, 1'b0, 5'd9, 1'b1, 1'b0, 5'd8, 1'b1, 1'b0, 1'b0, 5'b00000, 5'b00000);
        tbl[1]  = mk(5'd1, 5'd2, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 5'b00010, 5'b00010);
        tbl[2]  = mk(5'd5, 5'd0, 1'b0, 1'b0, 5'd5, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 5'b11100, 5'b00000);
        tbl[3]  = mk(5'd3, 5'd0, 1'b0, 1'b0, 5'd3, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 5'b11100, 5'b11100);
        tbl[4]  = mk(5'd7, 5'd3, 1'b0, 1'b0, 5'd3, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 5'b00000, 5'b00000);
        tbl[5]  = mk(5'd7, 5'd3, 1'b1, 1'b0, 5'd3, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 5'b11100, 5'b11100);
        tbl[6]  = mk(5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 5'b00000, 5'b00000);
        tbl[7]  = mk(5'd6, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd6, 1'b1, 1'b0, 1'b0, 5'b11100, 5'b00000);
        tbl[8]  = mk(5'd6, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd6, 1'b0, 1'b0, 1'b0, 5'b00000, 5'b00000);
        tbl[9]  = mk(5'd3, 5'd0, 1'b0, 1'b1, 5'd3, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 5'b11100, 5'b11100);
        tbl[10] = mk(5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 5'b11100, 5'b00010);
        tbl[11] = mk(5'd3, 5'd0, 1'b0, 1'b0, 5'd3, 1'b1, 1'b1, 5'd0, 1'b0, 1'b1, 1'b1, 5'b11100, 5'b11100);
        tbl[12] = mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 5'b00000, 5'b00000);
        tbl[13] = mk(5'd3, 5'd0, 1'b0, 1'b0, 5'd3, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 5'b00000, 5'b00000);

        // Reset with wait request, branch and a load-use hazard all asserted.
        rst = 1'b0;
        drive(mk(5'd3, 5'd0, 1'b0, 1'b1, 5'd3, 1'b1, 1'b1, 5'd3, 1'b1, 1'b1, 1'b0, 5'b0, 5'b0));
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("rst.outs", {27'd0, freeze_pc, freeze_if_id, bubble_id_exe, flush_if_id, freeze_back}, 0);
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        chk("rst.stall_cnt", {16'd0, stall_cnt}, 0);
        chk("rst.timeout", {31'd0, mem_timeout}, 0);
        chk("rst.state", {31'd0, state_dbg}, 0);
        @(posedge clk);
        #1;
        drive(idle);
        rst = 1'b1;
`ifdef HAZARD_FORWARDING_EN
        chk("fwd_en", {31'd0, fwd_en}, 1);
`else
        chk("fwd_en", {31'd0, fwd_en}, 0);
`endif

        for (int i = 0; i < 14; i++) step($sformatf("vec%0d", i), tbl[i], 1'b0);

        // Load r3 then consumer of r3 as it walks EXE -> MEM -> WB.
        step("ld.c1", mk(5'd3, 5'd0, 1'b0, 1'b0, 5'd3, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 5'b11100, 5'b11100), 1'b0);
        step("ld.c2", mk(5'd3, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0, 5'b11100, 5'b00000), 1'b0);
        step("ld.c3", mk(5'd3, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 5'b00000, 5'b00000), 1'b0);
        step("ld.r0", mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 5'b00000, 5'b00000), 1'b0);

        // ADD writes r5; consumer reads r5 on src2.
        base = exp_stall;
        step("add.c1", mk(5'd1, 5'd5, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 5'b11100, 5'b00000), 1'b0);
        step("add.c2", mk(5'd1, 5'd5, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 5'b11100, 5'b00000), 1'b0);
        step("add.c3", mk(5'd1, 5'd5, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 5'b00000, 5'b00000), 1'b0);
        @(negedge clk);
`ifdef HAZARD_FORWARDING_EN
        chk("add.delta", {16'd0, stall_cnt} - base, 0);
`else
        chk("add.delta", {16'd0, stall_cnt} - base, 2);
`endif
        @(posedge clk);
        #1;

        // SRAM wait: ready low 3 cycles, high on the 4th.
        base = exp_stall;
        step("wt.c1", mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 5'b11001, 5'b11001), 1'b0);
        step("wt.c2", mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 5'b11001, 5'b11001), 1'b1);
        step("wt.c3", mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 5'b11001, 5'b11001), 1'b1);
        step("wt.c4", mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 5'b00000, 5'b00000), 1'b1);
        step("wt.c5", idle, 1'b0);
        chk("wt.delta", exp_stall - base, {16'd0, stall_cnt} - base);

        // Timeout: ready never arrives; released on the 5th cycle, flag sticky.
        step("to.c1", mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 5'b11001, 5'b11001), 1'b0);
        for (int i = 2; i <= 4; i++)
            step($sformatf("to.c%0d", i),
                 mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 5'b11001, 5'b11001), 1'b1);
        step("to.c5", mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 5'b00000, 5'b00000), 1'b1);
        exp_to = 1'b1;
        step("to.c6", idle, 1'b0);
        step("to.c7", idle, 1'b0);

        // Priority: wait beats load-use beats branch.
        step("pr.c1", mk(5'd3, 5'd0, 1'b0, 1'b1, 5'd3, 1'b1, 1'b1, 5'd0, 1'b0, 1'b1, 1'b0, 5'b11001, 5'b11001), 1'b0);
        step("pr.c2", mk(5'd3, 5'd0, 1'b0, 1'b1, 5'd3, 1'b1, 1'b1, 5'd0, 1'b0, 1'b1, 1'b1, 5'b11100, 5'b11100), 1'b1);
        step("pr.c3", mk(5'd3, 5'd0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 5'b00010, 5'b00010), 1'b0);
        step("pr.c4", idle, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
